// File: rtl/smi_axis_input_adaptor_pkg.sv
// smi_axis_input_adaptor_pkg: shared SMI constants, keep-to-EOFC helper and hold-stage states.
package smi_axis_input_adaptor_pkg;
  localparam int EofcWidth = 8;
  localparam logic [EofcWidth-1:0] EOFC_MID = '0;
  typedef struct packed {
    logic [EofcWidth-1:0] count;
    logic contig;
  } KeepEofc;
  typedef enum logic [1:0] {H_EMPTY, H_WAIT, H_LAST} HState;
  // Counts the run of ones from bit 0; any one after the run breaks contiguity.
  function automatic KeepEofc keepToEofc(input logic [63:0] keep, input int width);
    KeepEofc r;
    logic run;
    r.count = '0;
    r.contig = 1'b1;
    run = 1'b1;
    for (int i = 0; i < 64; i++) begin
      if (i < width) begin
        if (keep[i] && run) r.count = r.count + 1'b1;
        else if (keep[i]) r.contig = 1'b0;
        else run = 1'b0;
      end
    end
    return r;
  endfunction
endpackage

// File: rtl/smi_axis_input_adaptor_encoder.sv
// smi_keep_eofc_encoder: combinational AXIS keep/last to SMI EOFC, null and protocol-error flags.
module smi_keep_eofc_encoder
  import smi_axis_input_adaptor_pkg::*;
#(
  parameter int KeepWidth = 8
) (
  input  logic [KeepWidth-1:0] keep,
  input  logic                 last,
  output logic [EofcWidth-1:0] eofc,
  output logic                 isNull,
  output logic                 err
);
  KeepEofc r;
  logic [63:0] keepWide;
  always_comb begin
    keepWide = '0;
    keepWide[KeepWidth-1:0] = keep;
    r = keepToEofc(keepWide, KeepWidth);
  end
  assign eofc = last ? r.count : EOFC_MID;
  assign isNull = keep == '0;
  // Null non-last beats also land here: not all ones and not last.
  assign err = !r.contig || (!last && !(&keep));
endmodule

// File: rtl/smi_axis_input_adaptor.sv
// smi_axis_input_adaptor: AXIS slave to SMI frame converter with a one-beat lookahead hold
// register so a trailing null last beat folds into the previous word's EOFC.
module smi_axis_input_adaptor
  import smi_axis_input_adaptor_pkg::*;
#(
  parameter int DataIndexSize = 3,
  parameter int UserWidth = 1,
  parameter int DataWidth = (1 << DataIndexSize) * 8,
  parameter int KeepWidth = 1 << DataIndexSize
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 axisInValid,
  input  logic [DataWidth-1:0] axisInData,
  input  logic [KeepWidth-1:0] axisInKeep,
  input  logic [UserWidth-1:0] axisInUser,
  input  logic                 axisInLast,
  output logic                 axisInReady,
  output logic                 smiOutValid,
  output logic [DataWidth-1:0] smiOutData,
  output logic [EofcWidth-1:0] smiOutEofc,
  output logic [UserWidth-1:0] smiOutUser,
  input  logic                 smiOutStop,
  output logic                 protoError
);
  HState hState, hNext;
  logic [DataWidth-1:0] hData;
  logic [EofcWidth-1:0] hEofc, encEofc;
  logic [UserWidth-1:0] hUser;
  logic encNull, encErr, oFree, accept, moveHO, loadH, forceFull, errNow;
  smi_keep_eofc_encoder #(.KeepWidth(KeepWidth)) encoder (
    .keep(axisInKeep),
    .last(axisInLast),
    .eofc(encEofc),
    .isNull(encNull),
    .err(encErr)
  );
  assign oFree = !smiOutValid || !smiOutStop;
  assign axisInReady = rstn && (hState == H_EMPTY || oFree);
  assign accept = axisInValid && axisInReady;
  always_comb begin
    hNext = hState;
    moveHO = 1'b0;
    loadH = 1'b0;
    forceFull = 1'b0;
    // A null last beat is only legitimate as the tail of a held non-last beat.
    errNow = accept && (encErr || (encNull && axisInLast && hState != H_WAIT));
    case (hState)
      H_EMPTY: loadH = accept && !encNull;
      H_WAIT: begin
        moveHO = accept && (!encNull || axisInLast);
        loadH = accept && !encNull;
        forceFull = accept && encNull && axisInLast;
        hNext = forceFull ? H_EMPTY : hState;
      end
      H_LAST: begin
        moveHO = oFree;
        loadH = oFree && accept && !encNull;
        hNext = oFree ? H_EMPTY : hState;
      end
      default: hNext = H_EMPTY;
    endcase
    if (loadH) hNext = axisInLast ? H_LAST : H_WAIT;
  end
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      hState <= H_EMPTY;
      hData <= '0;
      hEofc <= '0;
      hUser <= '0;
      smiOutValid <= 1'b0;
      smiOutData <= '0;
      smiOutEofc <= '0;
      smiOutUser <= '0;
      protoError <= 1'b0;
    end else begin
      hState <= hNext;
      protoError <= errNow;
      if (loadH) begin
        hData <= axisInData;
        hEofc <= encEofc;
        hUser <= axisInUser;
      end
      if (moveHO) begin
        smiOutValid <= 1'b1;
        smiOutData <= hData;
        smiOutEofc <= forceFull ? EofcWidth'(KeepWidth) : hEofc;
        smiOutUser <= hUser;
      end else if (!smiOutStop) begin
        smiOutValid <= 1'b0;
      end
    end
  end
endmodule

// File: doc/smi_axis_input_adaptor.md
Name: smi_axis_input_adaptor

Overview:
- AXI Stream slave to SMI Frame converter; the input-side counterpart of the SMI-to-AXIS output adaptor.
- Accepts external AXIS beats with keep/last/user sideband and emits SMI frame words with an EOFC byte count.
- Uses a one-beat lookahead hold register so that a trailing null (keep = 0) last beat is merged into the preceding beat's EOFC.
- Sits at the boundary between an external AXIS source and the SMI fabric.

Parameters:
- DataIndexSize, 3, log2 of bytes per data word.
- UserWidth, 1, AXI user width; tie the input low if unused.
- DataWidth, (1<<DataIndexSize)*8, data width (derived).
- KeepWidth, 1<<DataIndexSize, keep width (derived).

Ports:
- clk  in  1  clock; all state updates on its rising edge.
- rstn  in  1  asynchronous active-low reset.
- axisInValid  in  1  AXIS tvalid.
- axisInData  in  DataWidth  AXIS tdata.
- axisInKeep  in  KeepWidth  AXIS tkeep.
- axisInUser  in  UserWidth  AXIS tuser.
- axisInLast  in  1  AXIS tlast.
- axisInReady  out  1  AXIS tready.
- smiOutValid  out  1  SMI valid.
- smiOutData  out  DataWidth  SMI data.
- smiOutEofc  out  8  0 = mid-frame; N = last word with N valid bytes (1..KeepWidth).
- smiOutUser  out  UserWidth  user carried with the word.
- smiOutStop  in  1  SMI backpressure; transfer when smiOutValid && !smiOutStop.
- protoError  out  1  one-cycle pulse on a protocol violation.

Behaviour:
- Reset (async, rstn low): hValid=0, oValid=0, smiOutValid=0, smiOutEofc=0, smiOutData/User=0, protoError=0. axisInReady=0 while in reset. Any partial frame is discarded. The first accept can occur in the first cycle after rstn deasserts.
- Stages:
  - H (hold): data, eofc, user, hValid.
  - O (output register): drives the smi* ports directly.
- Signals:
  - oFree = !oValid || !smiOutStop.
  - Accept = axisInValid && axisInReady.
  - axisInReady = !hValid || oFree. This is registered-state based with no combinational path from axisInValid.
- EOFC encoding at accept:
  - last=0: eofc=0; keep must be all ones.
  - last=1: eofc = count of contiguous ones from keep bit 0; keep must be that contiguous prefix.
- H state machine:
  - EMPTY: on accept of a non-null beat, load H -> WAIT (non-last) or LAST (last). On accept of a null last beat (keep=0, last=1): discard, pulse protoError (empty frame), stay EMPTY.
  - WAIT (non-last held):
    - accept of a null last beat with oFree: move H to O with eofc forced to KeepWidth -> EMPTY.
    - accept of a non-null beat with oFree: H -> O, load new beat -> WAIT or LAST.
    - no accept: hold (H is never released without a successor).
  - LAST: when oFree, H -> O. If an accept occurs in the same cycle, load the new beat; otherwise -> EMPTY.
- O: loads only from H when oFree; clears when it transfers with no reload.
- Null non-last beat (keep=0, last=0): discard, pulse protoError.
- Non-contiguous keep, or partial keep without last: pulse protoError and still forward the word, with eofc computed by the leading-ones count (or 0 if not last).
- Latency:
  - Last beat accepted in cycle N appears on SMI in cycle N+2 when unstalled.
  - Non-last beat appears 1 cycle after its successor is accepted.
  - Sustained throughput is one beat per cycle when smiOutStop=0.
- smiOut* remain stable while smiOutValid && smiOutStop.
- Simultaneous O transfer and H->O reload in one cycle is legal and expected.

Decomposition:
- Shared SMI package: EOFC width constant (8), EOFC_MID=0, a keep-to-EOFC function (returns count plus a contiguity flag), and H state encoding (EMPTY/WAIT/LAST).
- One natural sub-module: smi_keep_eofc_encoder (combinational keep/last -> eofc, null, error), reusable by other AXIS adaptors.
- H/O control stays in the top level.

Test Plan:
- 3-beat frame with keep=FF,FF,0F and last on beat 3, smiOutStop=0 -> SMI words with eofc 0,0,4, correct data; beat 3 appears 2 cycles after its accept.
- 2-beat frame with keep=FF then a null last beat (keep=00) -> exactly 1 SMI word with eofc=8; no protoError.
- Lone null last beat -> no SMI word; protoError pulses once; axisInReady stays 1.
- keep=0xA5 with last=1 -> word forwarded with eofc=1; protoError=1 for one cycle.
- smiOutStop held high for 5 cycles during a 10-beat stream -> axisInReady drops once H and O are full; no loss or duplication; smiOut* stable while stalled; throughput returns to 1/cycle after release.
- rstn pulsed low while WAIT holds a beat -> all valids clear immediately (async); next frame after reset is emitted intact with correct eofc.
